// File: rtl/x_feed_pkg.sv
// Shared types and sizing for the X-feed row-register scheduler.
package x_feed_pkg;
    localparam int XR_DEPTH = 32;
    localparam int XR_IDX_W = 5;
    localparam int XR_ROWS  = 8;
    localparam int XR_MAX_K = XR_DEPTH - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } feed_state_e;
endpackage

// File: rtl/x_feed_skew.sv
// Per-row drain window: row r shifts while r <= c <= r+K.
module x_feed_skew
    import x_feed_pkg::*;
#(
    parameter int ROWS = XR_ROWS,
    parameter int CW   = 6
) (
    input  logic [CW-1:0]       c,
    input  logic [XR_IDX_W-1:0] k,
    output logic [ROWS-1:0]     en
);
    always_comb begin
        en = '0;
        for (int r = 0; r < ROWS; r++) begin
            en[r] = (c >= CW'(r)) && (c <= CW'(r) + CW'(k));
        end
    end
endmodule

// File: rtl/x_feed_sched.sv
// Loads a tile of column beats into the X row registers, then drains it with a
// one-cycle-per-row skew.
//   state    | meaning
//   ST_IDLE  | waiting for the first beat of a tile (written at index 0)
//   ST_LOAD  | accepting beats, b = next write index
//   ST_DRAIN | issuing skewed shift commands, c = drain step
//   ST_DONE  | one-cycle completion pulse
module x_feed_sched
    import x_feed_pkg::*;
#(
    parameter int ROWS = XR_ROWS
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [ROWS*8-1:0]   IN_DATA,
    input  logic                IN_LAST,
    input  logic                STALL,
    output logic [ROWS-1:0]     XR_EN,
    output logic                XR_WRITE,
    output logic [XR_IDX_W-1:0] XR_IDX,
    output logic [ROWS*8-1:0]   XR_DIN,
    output logic                XR_VALID_IN,
    output logic [XR_IDX_W-1:0] TILE_LEN,
    output logic                BUSY,
    output logic                DONE,
    output logic                TRUNC
);
    localparam int CW = $clog2(XR_MAX_K + ROWS);
    localparam logic [XR_IDX_W-1:0] B_LAST = XR_IDX_W'(XR_MAX_K - 1);

    feed_state_e          state_q, state_d;
    logic [XR_IDX_W-1:0]  b_q, b_d, k_q, k_d;
    logic [CW-1:0]        c_q, c_d, c_last;
    logic [ROWS-1:0]      skew_en;
    logic                 accept;

    logic [ROWS-1:0]      en_d;
    logic                 write_d, vin_d, trunc_d;
    logic [XR_IDX_W-1:0]  idx_d;
    logic [ROWS*8-1:0]    din_d;

    assign IN_READY = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign accept   = IN_VALID && IN_READY;
    assign BUSY     = (state_q != ST_IDLE);
    assign DONE     = (state_q == ST_DONE);
    assign TILE_LEN = k_q;
    assign c_last   = CW'(k_q) + CW'(ROWS - 1);

    x_feed_skew #(.ROWS(ROWS), .CW(CW)) u_skew (
        .c  (c_q),
        .k  (k_q),
        .en (skew_en)
    );

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        k_d     = k_q;
        c_d     = c_q;
        en_d    = '0;
        write_d = 1'b0;
        vin_d   = 1'b0;
        trunc_d = 1'b0;
        idx_d   = '0;
        din_d   = '0;
        case (state_q)
            ST_IDLE, ST_LOAD: begin
                // b_q is always 0 in IDLE, so the first beat lands at index 0
                if (accept) begin
                    en_d    = '1;
                    write_d = 1'b1;
                    vin_d   = 1'b1;
                    idx_d   = b_q;
                    din_d   = IN_DATA;
                    if (IN_LAST || (b_q == B_LAST)) begin
                        k_d     = b_q + 1'b1;
                        trunc_d = !IN_LAST;
                        b_d     = '0;
                        c_d     = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        b_d     = b_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DRAIN: begin
                if (!STALL) begin
                    en_d = skew_en;
                    if (c_q == c_last) begin
                        state_d = ST_DONE;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            b_q         <= '0;
            k_q         <= '0;
            c_q         <= '0;
            XR_EN       <= '0;
            XR_WRITE    <= 1'b0;
            XR_IDX      <= '0;
            XR_DIN      <= '0;
            XR_VALID_IN <= 1'b0;
            TRUNC       <= 1'b0;
        end else begin
            state_q     <= state_d;
            b_q         <= b_d;
            k_q         <= k_d;
            c_q         <= c_d;
            XR_EN       <= en_d;
            XR_WRITE    <= write_d;
            XR_IDX      <= idx_d;
            XR_DIN      <= din_d;
            XR_VALID_IN <= vin_d;
            TRUNC       <= trunc_d;
        end
    end
endmodule
